// File: rtl/d1_bus_arbiter.sv
// d1_bus_arbiter: round-robin arbiter sharing the single D1 slave port; the owner keeps the bus for its whole burst
//
// Ports:
//   clk_i, rst_i          clock and asynchronous active-high reset
//   m_*_i                 per-requester address/write data/write/size/burst/claim, requester i in slice i
//   m_read_data_o         slave read data broadcast to every requester
//   m_readyout_o/m_resp_o slave ready/response routed to the owner only, 0 elsewhere
//   grant_o               registered one-hot owner
//   wdog_expire_o         one-cycle pulse on a watchdog forced release
//   s_*_o                 owner's signals muxed to the slave, all zero without a grant
//   s_*_i                 slave read data, ready and error response
// Optional feature: define ARB_WATCHDOG_EN to bound ownership to MAX_HOLD cycles.
module d1_bus_arbiter #(
    parameter int N_REQ    = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ*32-1:0] m_addr_i,
    input  logic [N_REQ*32-1:0] m_write_data_i,
    input  logic [N_REQ-1:0]    m_write_i,
    input  logic [N_REQ*3-1:0]  m_size_i,
    input  logic [N_REQ*3-1:0]  m_burst_i,
    input  logic [N_REQ-1:0]    m_claim_i,
    output logic [31:0]         m_read_data_o,
    output logic [N_REQ-1:0]    m_readyout_o,
    output logic [N_REQ-1:0]    m_resp_o,
    output logic [N_REQ-1:0]    grant_o,
    output logic                wdog_expire_o,
    output logic [31:0]         s_addr_o,
    output logic [31:0]         s_write_data_o,
    output logic                s_write_o,
    output logic [2:0]          s_size_o,
    output logic [2:0]          s_burst_o,
    output logic                s_claim_o,
    input  logic [31:0]         s_read_data_i,
    input  logic                s_readyout_i,
    input  logic                s_resp_i
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
    state_t           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [IW-1:0]    owner_q, ptr_q, ptr_d, win;
    logic [IW:0]      idx;
    logic [N_REQ-1:0] eligible;
    logic             found;
    logic             owner_claim;
`ifdef ARB_WATCHDOG_EN
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);
    logic [CW-1:0]    cnt_q;
    logic [N_REQ-1:0] mask_q;
    logic             wdog_q;
    // a requester evicted by the watchdog sits out until it has dropped its claim once
    assign eligible      = m_claim_i & ~mask_q;
    assign wdog_expire_o = wdog_q;
`else
    assign eligible      = m_claim_i;
    assign wdog_expire_o = 1'b0;
`endif
    assign owner_claim   = m_claim_i[owner_q];
    assign ptr_d         = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign grant_o       = grant_q;
    assign s_claim_o     = |grant_q;
    assign m_read_data_o = s_read_data_i;
    assign m_readyout_o  = grant_q & {N_REQ{s_readyout_i}};
    assign m_resp_o      = grant_q & {N_REQ{s_resp_i}};
    // first eligible claimant at or after the pointer, wrapping explicitly
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            idx = (idx >= (IW+1)'(N_REQ)) ? idx - (IW+1)'(N_REQ) : idx;
            if (!found && eligible[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end
    // AND-OR mux on the one-hot grant; no grant yields all zeros
    always_comb begin
        s_addr_o       = '0;
        s_write_data_o = '0;
        s_write_o      = 1'b0;
        s_size_o       = '0;
        s_burst_o      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            s_addr_o       = s_addr_o | ({32{grant_q[i]}} & m_addr_i[32*i+:32]);
            s_write_data_o = s_write_data_o | ({32{grant_q[i]}} & m_write_data_i[32*i+:32]);
            s_write_o      = s_write_o | (grant_q[i] & m_write_i[i]);
            s_size_o       = s_size_o | ({3{grant_q[i]}} & m_size_i[3*i+:3]);
            s_burst_o      = s_burst_o | ({3{grant_q[i]}} & m_burst_i[3*i+:3]);
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef ARB_WATCHDOG_EN
            cnt_q   <= '0;
            mask_q  <= '0;
            wdog_q  <= 1'b0;
`endif
        end else begin
`ifdef ARB_WATCHDOG_EN
            wdog_q <= 1'b0;
            mask_q <= mask_q & m_claim_i;
`endif
            case (state_q)
                IDLE: if (found) begin
                    state_q <= OWN;
                    owner_q <= win;
                    grant_q <= N_REQ'(1) << win;
`ifdef ARB_WATCHDOG_EN
                    cnt_q   <= '0;
`endif
                end
                OWN: if (!owner_claim) begin
                    if (s_readyout_i) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        ptr_q   <= ptr_d;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
`ifdef ARB_WATCHDOG_EN
                else if (cnt_q >= HOLD_LIM) begin
                    // expiry only takes effect on a completed beat
                    if (s_readyout_i) begin
                        state_q         <= IDLE;
                        grant_q         <= '0;
                        ptr_q           <= ptr_d;
                        wdog_q          <= 1'b1;
                        mask_q[owner_q] <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                DRAIN: if (s_readyout_i) begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    ptr_q   <= ptr_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_d1_bus_arbiter.sv
// tb_d1_bus_arbiter: randomized and directed scoreboard bench for d1_bus_arbiter
module tb_d1_bus_arbiter;
    localparam int N  = 2;
    localparam int MH = 8;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*32-1:0] m_addr = '0, m_wdata = '0;
    logic [N-1:0]    m_write = '0, claim = '1;
    logic [N*3-1:0]  m_size = '0, m_burst = '0;
    logic [31:0]     s_rdata = '0;
    logic            rdy = 1'b0, resp = 1'b0;
    logic [31:0]     m_rdata_o, s_addr_o, s_wdata_o;
    logic [N-1:0]    m_rdy_o, m_resp_o, grant_o;
    logic            wdog_o, s_write_o, s_claim_o;
    logic [2:0]      s_size_o, s_burst_o;

    d1_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_addr_i(m_addr), .m_write_data_i(m_wdata), .m_write_i(m_write),
        .m_size_i(m_size), .m_burst_i(m_burst), .m_claim_i(claim),
        .m_read_data_o(m_rdata_o), .m_readyout_o(m_rdy_o), .m_resp_o(m_resp_o),
        .grant_o(grant_o), .wdog_expire_o(wdog_o),
        .s_addr_o(s_addr_o), .s_write_data_o(s_wdata_o), .s_write_o(s_write_o),
        .s_size_o(s_size_o), .s_burst_o(s_burst_o), .s_claim_o(s_claim_o),
        .s_read_data_i(s_rdata), .s_readyout_i(rdy), .s_resp_i(resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] grant, rdy, resp;
        logic [31:0]  addr, wdata, rdata;
        logic         wr, claim, wd;
        logic [2:0]   size, burst;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;
    int n_chk = 0, n_pass = 0;

    // reference model: who owns the bus, whether it is draining, rr pointer, cycles held, eviction masks
    int owner = -1, ptr = 0, held = 0;
    bit drain = 0, wd = 0;
    bit masked[N];
    logic [N-1:0] nc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; held = 0; drain = 0; wd = 0;
        for (int i = 0; i < N; i++) masked[i] = 0;
    endtask

    task automatic release_bus();
        ptr = (owner + 1) % N;
        owner = -1;
        drain = 0;
    endtask

    // one rising edge with the inputs currently driven
    task automatic model_update();
        bit forced = 0;
        if (rst) begin
            model_reset();
            return;
        end
        wd = 0;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int i = (ptr + k) % N;
                if (owner < 0 && claim[i] && !masked[i]) begin
                    owner = i;
                    held = 0;
                end
            end
        end else if (drain || !claim[owner]) begin
            if (rdy) release_bus();
            else drain = 1;
        end else if (WD && held >= MH - 1) begin
            if (rdy) forced = 1;
        end else begin
            held++;
        end
        for (int i = 0; i < N; i++) if (!claim[i]) masked[i] = 0;
        if (forced) begin
            masked[owner] = 1;
            wd = 1;
            release_bus();
        end
    endtask

    task automatic push_exp();
        exp_t e;
        bit o = owner >= 0;
        e.grant = o ? N'(1) << owner : '0;
        e.claim = o;
        e.addr  = o ? m_addr[32*owner+:32] : '0;
        e.wdata = o ? m_wdata[32*owner+:32] : '0;
        e.wr    = o ? m_write[owner] : 1'b0;
        e.size  = o ? m_size[3*owner+:3] : '0;
        e.burst = o ? m_burst[3*owner+:3] : '0;
        e.rdy   = (o && rdy) ? N'(1) << owner : '0;
        e.resp  = (o && resp) ? N'(1) << owner : '0;
        e.wd    = wd;
        e.rdata = s_rdata;
        q.push_back(e);
    endtask

    task automatic cycle(input logic [N-1:0] c, input logic r, input logic rs, input logic rs_t);
        @(negedge clk);
        model_update();
        claim = c; rdy = r; resp = rs; rst = rs_t;
        for (int i = 0; i < N; i++) begin
            m_addr[32*i+:32]  = $urandom;
            m_wdata[32*i+:32] = $urandom;
            m_size[3*i+:3]    = 3'($urandom);
            m_burst[3*i+:3]   = 3'($urandom);
        end
        m_write = N'($urandom);
        s_rdata = $urandom;
        if (rs_t) model_reset();
        push_exp();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("grant", 32'(grant_o), 32'(mon_e.grant));
                chk("s_claim", 32'(s_claim_o), 32'(mon_e.claim));
                chk("s_addr", s_addr_o, mon_e.addr);
                chk("s_wdata", s_wdata_o, mon_e.wdata);
                chk("s_write", 32'(s_write_o), 32'(mon_e.wr));
                chk("s_size", 32'(s_size_o), 32'(mon_e.size));
                chk("s_burst", 32'(s_burst_o), 32'(mon_e.burst));
                chk("m_readyout", 32'(m_rdy_o), 32'(mon_e.rdy));
                chk("m_resp", 32'(m_resp_o), 32'(mon_e.resp));
                chk("m_read_data", m_rdata_o, mon_e.rdata);
                chk("wdog_expire", 32'(wdog_o), 32'(mon_e.wd));
            end
        end
    end

    initial begin
        repeat (3) cycle(2'b11, 1'b1, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            repeat (4) cycle(2'b11, 1'b1, 1'b0, 1'b0);
            cycle(owner == 0 ? 2'b10 : 2'b01, 1'b1, 1'b0, 1'b0);
        end
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(2'b10, 1'b0, 1'b0, 1'b0);
        repeat (4) cycle(2'b10, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle(2'b11, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(2'b10, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b01, 1'b1, 1'b0, 1'b0);
        repeat (100) cycle(2'b11, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(2'b00, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            nc = claim;
            for (int i = 0; i < N; i++)
                nc[i] = !nc[i] ? ($urandom_range(0, 2) == 0)
                      : (owner == i) ? ($urandom_range(0, 3) != 0)
                      : ($urandom_range(0, 15) != 0);
            cycle(nc, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, n == 200);
        end
        @(negedge clk);
        #5;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
